// File: rtl/tetris_game_fsm_pkg.sv
// Shared types and defaults for the Tetris game sequencer.
// Optional feature macro: TETRIS_PAUSE_EN (see tetris_game_fsm).
package tetris_pkg;

  typedef enum logic [3:0] {
    S_PRE_GAME  = 4'd0,
    S_PRE_BUF   = 4'd1,
    S_LOAD      = 4'd2,
    S_SPAWN_CHK = 4'd3,
    S_DROP      = 4'd4,
    S_UPDATE    = 4'd5,
    S_CHECK     = 4'd6,
    S_CLEAR     = 4'd7,
    S_GAME_OVER = 4'd8
  } game_state_t;

  localparam int DEF_ROWS        = 20;
  localparam int DEF_DROP_PERIOD = 25_000_000;
  localparam int DEF_LINE_CNT_W  = 16;

  function automatic int ROW_IDX_W(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

endpackage

// File: rtl/tetris_game_fsm_gravity_timer.sv
// Gravity step counter: counts 0..DROP_PERIOD-1 while enabled, tick on the
// terminal count; restart forces the count back to 0.
module gravity_timer #(
  parameter int DROP_PERIOD = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DROP_PERIOD > 2) ? $clog2(DROP_PERIOD) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(DROP_PERIOD - 1);

  logic [CNT_W-1:0] r_cnt;

  assign tick = enable & (r_cnt == TERM);

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == TERM) ? '0 : r_cnt + 1'b1;
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/tetris_game_fsm.sv
// Game sequencer driving the board datapath: load, gravity, commit, line clears.
// Define TETRIS_PAUSE_EN to let `pause` freeze gravity while dropping.
module tetris_game_fsm
  import tetris_pkg::*;
#(
  parameter int ROWS        = DEF_ROWS,
  parameter int DROP_PERIOD = DEF_DROP_PERIOD,
  parameter int LINE_CNT_W  = DEF_LINE_CNT_W
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        start_game,
  input  logic                        pause,
  input  logic                        filled_under,
  input  logic                        spawn_blocked,
  input  logic [ROWS-1:0]             completed_lines,
  input  logic                        clear_done,
  output logic                        load_block,
  output logic                        drop_step,
  output logic                        update_board_state,
  output logic                        clear_line,
  output logic [ROW_IDX_W(ROWS)-1:0]  clear_row,
  output logic [LINE_CNT_W-1:0]       lines_cleared,
  output logic                        game_over
);

  localparam int RW = ROW_IDX_W(ROWS);

  game_state_t           r_state;
  game_state_t           w_next;
  logic                  w_paused;
  logic                  w_tick;
  logic                  w_any_full;
  logic [RW-1:0]         w_low_idx;
  logic                  r_load_block;
  logic                  r_update;
  logic                  r_clear_line;
  logic                  r_game_over;
  logic [RW-1:0]         r_clear_row;
  logic [LINE_CNT_W-1:0] r_lines;

`ifdef TETRIS_PAUSE_EN
  assign w_paused = pause;
`else
  assign w_paused = pause & 1'b0;
`endif

  gravity_timer #(.DROP_PERIOD(DROP_PERIOD)) u_gravity (
    .clock   (clock),
    .reset   (reset),
    .enable  ((r_state == S_DROP) & ~w_paused),
    .restart (r_state != S_DROP),
    .tick    (w_tick)
  );

  assign w_any_full = |completed_lines;

  // Scan from the top so the lowest full row wins.
  always_comb begin
    w_low_idx = '0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      w_low_idx = completed_lines[i] ? RW'(i) : w_low_idx;
    end
  end

  always_comb begin
    w_next = S_PRE_GAME;
    case (r_state)
      S_PRE_GAME:  w_next = start_game ? S_PRE_BUF : S_PRE_GAME;
      S_PRE_BUF:   w_next = start_game ? S_PRE_BUF : S_LOAD;
      S_LOAD:      w_next = S_SPAWN_CHK;
      S_SPAWN_CHK: w_next = spawn_blocked ? S_GAME_OVER : S_DROP;
      S_DROP:      w_next = (w_tick && filled_under) ? S_UPDATE : S_DROP;
      S_UPDATE:    w_next = S_CHECK;
      S_CHECK:     w_next = w_any_full ? S_CLEAR : S_LOAD;
      S_CLEAR:     w_next = clear_done ? S_CHECK : S_CLEAR;
      S_GAME_OVER: w_next = start_game ? S_PRE_BUF : S_GAME_OVER;
      default:     w_next = S_PRE_GAME;
    endcase
  end

  // Outputs are registered alongside the state so they stay Moore and clean.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_PRE_GAME;
      r_load_block <= 1'b0;
      r_update     <= 1'b0;
      r_clear_line <= 1'b0;
      r_game_over  <= 1'b0;
      r_clear_row  <= '0;
      r_lines      <= '0;
    end else begin
      r_state      <= w_next;
      r_load_block <= (w_next == S_LOAD);
      r_update     <= (w_next == S_UPDATE);
      r_clear_line <= (w_next == S_CLEAR);
      r_game_over  <= (w_next == S_GAME_OVER);
      if (r_state == S_CHECK && w_any_full) begin
        r_clear_row <= w_low_idx;
      end
      if (r_state == S_PRE_BUF && !start_game) begin
        r_lines <= '0;
      end else if (r_state == S_CLEAR && clear_done && r_lines != {LINE_CNT_W{1'b1}}) begin
        r_lines <= r_lines + 1'b1;
      end
    end
  end

  assign load_block         = r_load_block;
  assign update_board_state = r_update;
  assign clear_line         = r_clear_line;
  assign game_over          = r_game_over;
  assign clear_row          = r_clear_row;
  assign lines_cleared      = r_lines;
  assign drop_step          = (r_state == S_DROP) & w_tick & ~filled_under;

endmodule

// File: tb/tb_tetris_game_fsm.sv
// Randomized bench for tetris_game_fsm against a cycle-level game model.
module tb_tetris_game_fsm;

  localparam int ROWS = 20;
  localparam int DP   = 4;
  localparam int LW   = 2;
  localparam int LMAX = (1 << LW) - 1;

  localparam int M_IDLE = 0, M_BUF = 1, M_LOAD = 2, M_SPAWN = 3, M_FALL = 4,
                 M_COMMIT = 5, M_SCAN = 6, M_CLEAR = 7, M_OVER = 8;

  logic            clock = 1'b0;
  logic            reset, start_game, pause, filled_under, spawn_blocked, clear_done;
  logic [ROWS-1:0] completed_lines;
  logic            load_block, drop_step, update_board_state, clear_line, game_over;
  logic [4:0]      clear_row;
  logic [LW-1:0]   lines_cleared;

  always #5 clock = ~clock;

  tetris_game_fsm #(.ROWS(ROWS), .DROP_PERIOD(DP), .LINE_CNT_W(LW)) dut (
    .clock              (clock),
    .reset              (reset),
    .start_game         (start_game),
    .pause              (pause),
    .filled_under       (filled_under),
    .spawn_blocked      (spawn_blocked),
    .completed_lines    (completed_lines),
    .clear_done         (clear_done),
    .load_block         (load_block),
    .drop_step          (drop_step),
    .update_board_state (update_board_state),
    .clear_line         (clear_line),
    .clear_row          (clear_row),
    .lines_cleared      (lines_cleared),
    .game_over          (game_over)
  );

  int n_pass  = 0;
  int n_total = 0;
  int m_phase, m_wait, m_row, m_lines;
  int n_clears = 0, n_drops = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
  endtask

  function automatic int lowest_full(input logic [ROWS-1:0] v);
    for (int i = 0; i < ROWS; i++) if (v[i]) return i;
    return 0;
  endfunction

  task automatic randomize_inputs(input int cyc);
    reset         = (cyc > 50) && ($urandom_range(0, 199) == 0);
    start_game    = ($urandom_range(0, 9) < 4);
    pause         = ($urandom_range(0, 3) == 0);
    filled_under  = ($urandom_range(0, 9) < 3);
    spawn_blocked = ($urandom_range(0, 19) == 0);
    clear_done    = ($urandom_range(0, 9) < 3);
    if ($urandom_range(0, 9) < 5)
      completed_lines = ROWS'($urandom() & $urandom() & $urandom());
    else
      completed_lines = '0;
  endtask

  // Compare every output with what the game rules say for this cycle.
  task automatic check_outputs();
    logic gravity_on;
`ifdef TETRIS_PAUSE_EN
    gravity_on = !pause;
`else
    gravity_on = 1'b1;
`endif
    check_eq("load_block", load_block, m_phase == M_LOAD);
    check_eq("update_board_state", update_board_state, m_phase == M_COMMIT);
    check_eq("clear_line", clear_line, m_phase == M_CLEAR);
    check_eq("game_over", game_over, m_phase == M_OVER);
    check_eq("lines_cleared", lines_cleared, m_lines);
    check_eq("drop_step", drop_step,
             m_phase == M_FALL && gravity_on && m_wait == DP - 1 && !filled_under);
    if (m_phase == M_CLEAR) check_eq("clear_row", clear_row, m_row);
  endtask

  // Advance the game by one clock according to the sampled inputs.
  task automatic step_model();
    logic gravity_on;
`ifdef TETRIS_PAUSE_EN
    gravity_on = !pause;
`else
    gravity_on = 1'b1;
`endif
    if (reset) begin
      m_phase = M_IDLE; m_wait = 0; m_row = 0; m_lines = 0;
      return;
    end
    case (m_phase)
      M_IDLE:  if (start_game) m_phase = M_BUF;
      M_BUF:   if (!start_game) begin m_phase = M_LOAD; m_lines = 0; end
      M_LOAD:  m_phase = M_SPAWN;
      M_SPAWN: begin
        if (spawn_blocked) m_phase = M_OVER;
        else begin m_phase = M_FALL; m_wait = 0; end
      end
      M_FALL: begin
        if (gravity_on) begin
          if (m_wait == DP - 1) begin
            if (filled_under) m_phase = M_COMMIT;
            else begin m_wait = 0; n_drops++; end
          end else m_wait++;
        end
      end
      M_COMMIT: m_phase = M_SCAN;
      M_SCAN: begin
        if (completed_lines != '0) begin m_row = lowest_full(completed_lines); m_phase = M_CLEAR; end
        else m_phase = M_LOAD;
      end
      M_CLEAR: begin
        if (clear_done) begin
          if (m_lines < LMAX) m_lines++;
          m_phase = M_SCAN;
          n_clears++;
        end
      end
      M_OVER: if (start_game) m_phase = M_BUF;
      default: m_phase = M_IDLE;
    endcase
  endtask

  initial begin
    reset = 1'b1; start_game = 1'b0; pause = 1'b0; filled_under = 1'b0;
    spawn_blocked = 1'b0; clear_done = 1'b0; completed_lines = '0;
    m_phase = M_IDLE; m_wait = 0; m_row = 0; m_lines = 0;
    repeat (2) @(posedge clock);
    #1;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      randomize_inputs(cyc);
      #3;
      check_outputs();
      step_model();
      @(posedge clock);
      #1;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
